// File: rtl/count_timer_pkg.sv
// rtl/count_timer_pkg.sv - mode-bit positions and mode encodings for count_timer
package count_timer_pkg;

    localparam int MODE_DIR_BIT = 0;
    localparam int MODE_OVF_BIT = 1;

    localparam logic UP    = 1'b0;
    localparam logic DOWN  = 1'b1;

    localparam logic WRAP  = 1'b0;
    localparam logic CLEAR = 1'b1;

endpackage

// File: rtl/count_timer_next.sv
// rtl/count_timer_next.sv - combinational next-count and wrap/reload condition
module count_timer_next
    import count_timer_pkg::*;
#(
    parameter int BIN = 32,
    parameter int TOP = 255
) (
    input  logic [BIN-1:0] count,
    input  logic [1:0]     mode,
    input  logic [BIN-1:0] match_value,
    output logic [BIN-1:0] next_count,
    output logic           wrap
);

    localparam logic [BIN-1:0] TOP_V = BIN'(TOP);
    localparam logic [BIN-1:0] ONE   = BIN'(1);

    logic clear_mode;
    logic [BIN-1:0] reload;

    assign clear_mode = (mode[MODE_OVF_BIT] == CLEAR);

    // Down-count reload target; a compare value above TOP is clamped so nothing above TOP is produced
    assign reload = (clear_mode && match_value <= TOP_V) ? match_value : TOP_V;

    // One count step: up wraps at TOP (or at the compare value in clear mode), down reloads at zero
    always_comb begin
        next_count = count;
        wrap       = 1'b0;
        if (mode[MODE_DIR_BIT] == UP) begin
            if (count == TOP_V || (clear_mode && count == match_value)) begin
                next_count = '0;
                wrap       = 1'b1;
            end else begin
                next_count = count + ONE;
            end
        end else begin
            if (count == '0) begin
                next_count = reload;
                wrap       = 1'b1;
            end else begin
                next_count = count - ONE;
            end
        end
    end

endmodule

// File: rtl/count_timer.sv
// rtl/count_timer.sv - up/down timer-counter with compare match and wrap pulse; option COUNT_TIMER_MATCH_REG_EN registers match
module count_timer
    import count_timer_pkg::*;
#(
    parameter int BIN = 32,
    parameter int TOP = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [1:0]     mode,
    input  logic [BIN-1:0] match_value,
    output logic [BIN-1:0] oCounter,
    output logic           match,
    output logic           ovf
);

    logic [BIN-1:0] next_count;
    logic           wrap;

    count_timer_next #(
        .BIN(BIN),
        .TOP(TOP)
    ) u_next (
        .count      (oCounter),
        .mode       (mode),
        .match_value(match_value),
        .next_count (next_count),
        .wrap       (wrap)
    );

    // Counter and wrap pulse advance only on enabled edges; the pulse drops whenever counting pauses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oCounter <= '0;
            ovf      <= 1'b0;
        end else if (enable) begin
            oCounter <= next_count;
            ovf      <= wrap;
        end else begin
            ovf      <= 1'b0;
        end
    end

`ifdef COUNT_TIMER_MATCH_REG_EN
    // Registered compare, one cycle behind the count, updated every edge regardless of enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match <= 1'b0;
        end else begin
            match <= (oCounter == match_value);
        end
    end
`else
    assign match = (oCounter == match_value);
`endif

endmodule

// File: tb/tb_count_timer.sv
// tb/tb_count_timer.sv - randomized self-checking bench for count_timer against a behavioural model
module tb_count_timer;

    localparam int BIN = 32;
    localparam int TOP = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [1:0]     mode;
    logic [BIN-1:0] match_value;
    logic [BIN-1:0] oCounter;
    logic           match;
    logic           ovf;

    int checks   = 0;
    int failures = 0;

    int m_count     = 0;
    bit m_ovf       = 1'b0;
    bit m_match_reg = 1'b0;

    always #5 clk = ~clk;

    count_timer #(
        .BIN(BIN),
        .TOP(TOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .match_value(match_value),
        .oCounter   (oCounter),
        .match      (match),
        .ovf        (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model of one rising edge, from the behavioural rules rather than the RTL structure
    task automatic model_edge();
        int mv;
        int old;
        int limit;
        int target;
        mv  = int'(match_value);
        old = m_count;
        m_match_reg = (old == mv);
        if (!enable) begin
            m_ovf = 1'b0;
        end else if (mode[0] == 1'b0) begin
            limit = (mode[1] && mv <= TOP && old <= mv) ? mv : TOP;
            m_ovf   = (old == limit);
            m_count = m_ovf ? 0 : old + 1;
        end else begin
            target  = mode[1] ? ((mv < TOP) ? mv : TOP) : TOP;
            m_ovf   = (old == 0);
            m_count = m_ovf ? target : old - 1;
        end
    endtask

    function automatic bit exp_match();
`ifdef COUNT_TIMER_MATCH_REG_EN
        return m_match_reg;
`else
        return (m_count == int'(match_value));
`endif
    endfunction

    task automatic check_outputs();
        check_eq("count", oCounter, 32'(m_count));
        check_eq("ovf", {31'b0, ovf}, {31'b0, m_ovf});
        check_eq("match", {31'b0, match}, {31'b0, exp_match()});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called at a falling edge: pulses reset well clear of any rising edge
    task automatic async_reset();
        #2 reset = 1'b1;
        m_count = 0;
        m_ovf = 1'b0;
        m_match_reg = 1'b0;
        #1;
        check_eq("async_rst_count", oCounter, 32'd0);
        check_eq("async_rst_ovf", {31'b0, ovf}, 32'd0);
        check_eq("async_rst_match", {31'b0, match}, {31'b0, exp_match()});
        #1 reset = 1'b0;
    endtask

    initial begin
        int held;
        int prev;
        int n;
        bit seen;

        reset = 1'b1;
        enable = 1'b0;
        mode = 2'b00;
        match_value = '0;
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Wrap up with compare 25
        mode = 2'b00;
        match_value = 32'd25;
        enable = 1'b1;
        step();
        check_eq("first_edge", oCounter, 32'd1);
        steps(300);

        // Wrap down from reset
        async_reset();
        mode = 2'b01;
        step();
        check_eq("down_first", oCounter, 32'd255);
        check_eq("down_first_ovf", {31'b0, ovf}, 32'd1);
        step();
        check_eq("down_second", oCounter, 32'd254);

        // Clear up, then shrink the compare value below the current count
        async_reset();
        mode = 2'b10;
        match_value = 32'd25;
        steps(60);
        n = 0;
        while (oCounter != 32'd20 && n < 300) begin
            step();
            n++;
        end
        check_eq("reach_20", oCounter, 32'd20);
        match_value = 32'd10;
        seen = 1'b0;
        prev = int'(oCounter);
        n = 0;
        while (!seen && n < 300) begin
            step();
            if (ovf) begin
                seen = 1'b1;
                check_eq("overrun_top", 32'(prev), 32'd255);
            end
            prev = int'(oCounter);
            n++;
        end
        check_eq("overrun_seen", {31'b0, seen}, 32'd1);
        steps(30);

        // Clear down, then a compare value above TOP
        async_reset();
        mode = 2'b11;
        match_value = 32'd25;
        steps(60);
        match_value = 32'd300;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 300) begin
            step();
            if (ovf) begin
                seen = 1'b1;
                check_eq("reload_clamp", oCounter, 32'd255);
            end
            n++;
        end
        check_eq("reload_seen", {31'b0, seen}, 32'd1);

        // Hold with enable low for three edges
        mode = 2'b00;
        match_value = 32'd40;
        steps(5);
        held = int'(oCounter);
        enable = 1'b0;
        steps(3);
        check_eq("hold", oCounter, 32'(held));
        enable = 1'b1;
        step();

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) match_value = 32'($urandom_range(0, 300));
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
